// File: rtl/timer_core_if.sv
// Bus-side bundle for timer_core: the control strobes and configuration coming from
// the register block, plus the timer status going to the interrupt controller.
interface timer_core_if #(
  parameter int WIDTH     = 16,
  parameter int PRE_WIDTH = 8
);
  logic                 en;
  logic                 mode;
  logic                 load;
  logic [WIDTH-1:0]     load_val;
  logic [PRE_WIDTH-1:0] prescale;
  logic                 irq_clr;
  logic [WIDTH-1:0]     count;
  logic                 tick;
  logic                 irq;
  logic                 running;

  modport master (
    output en, mode, load, load_val, prescale, irq_clr,
    input  count, tick, irq, running
  );

  modport slave (
    input  en, mode, load, load_val, prescale, irq_clr,
    output count, tick, irq, running
  );
endinterface

// File: rtl/timer_core.sv
// Programmable down-counting timer with prescaler, one-shot/periodic reload and a
// sticky interrupt flag. All outputs are registered.
module timer_core #(
  parameter int WIDTH     = 16,
  parameter int PRE_WIDTH = 8
) (
  input  logic         clk,
  input  logic         clr_b,
  timer_core_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state_q;
  logic [PRE_WIDTH-1:0] pre_q;
  logic [PRE_WIDTH-1:0] pre_d;
  logic [WIDTH-1:0]     count_q;
  logic [WIDTH-1:0]     count_d;
  logic [WIDTH-1:0]     reload_q;
  logic                 tick_q;
  logic                 irq_q;
  logic                 running_q;
  logic                 dec_hit;
  logic                 expiring;

  // ">=" rather than "==" so a prescale lowered mid-period cannot let pre_q run past it.
  assign dec_hit  = (pre_q >= bus.prescale);
  assign expiring = (count_q <= WIDTH'(1));
  assign pre_d    = pre_q + PRE_WIDTH'(1);
  assign count_d  = count_q - WIDTH'(1);

  always_ff @(posedge clk or negedge clr_b) begin
    if (!clr_b) begin
      state_q   <= IDLE;
      pre_q     <= '0;
      count_q   <= '0;
      reload_q  <= '0;
      tick_q    <= 1'b0;
      irq_q     <= 1'b0;
      running_q <= 1'b0;
    end else begin
      tick_q <= 1'b0;

      if (bus.irq_clr) begin
        irq_q <= 1'b0;
        if (state_q == DONE) begin
          state_q   <= IDLE;
          running_q <= 1'b0;
        end
      end

      // Later assignments win: load overrides a decrement, expiry overrides irq_clr.
      if (bus.load) begin
        reload_q <= bus.load_val;
        count_q  <= bus.load_val;
        pre_q    <= '0;
        if (bus.load_val != '0) begin
          state_q   <= RUN;
          running_q <= 1'b1;
        end else begin
          state_q   <= IDLE;
          running_q <= 1'b0;
        end
      end else if ((state_q == RUN) && bus.en) begin
        if (dec_hit) begin
          pre_q  <= '0;
          tick_q <= 1'b1;
          if (!expiring) begin
            count_q <= count_d;
          end else begin
            irq_q <= 1'b1;
            if (bus.mode) begin
              count_q <= reload_q;
            end else begin
              count_q   <= '0;
              state_q   <= DONE;
              running_q <= 1'b0;
            end
          end
        end else begin
          pre_q <= pre_d;
        end
      end
    end
  end

  assign bus.count   = count_q;
  assign bus.tick    = tick_q;
  assign bus.irq     = irq_q;
  assign bus.running = running_q;

endmodule

// File: tb/tb_timer_core.sv
// Self-checking bench for timer_core: a table of per-cycle vectors whose expected
// outputs flow through a scoreboard queue, plus hand-written reset sequences.
module tb_timer_core;

  localparam int WIDTH     = 16;
  localparam int PRE_WIDTH = 8;

  typedef struct {
    logic                 en;
    logic                 mode;
    logic                 load;
    logic [WIDTH-1:0]     load_val;
    logic [PRE_WIDTH-1:0] prescale;
    logic                 irq_clr;
    logic [WIDTH-1:0]     exp_count;
    logic                 exp_tick;
    logic                 exp_irq;
    logic                 exp_running;
  } vec_t;

  logic clk;
  logic clr_b;
  int   checks;
  int   errors;
  vec_t table_q[$];
  vec_t sb_q[$];

  timer_core_if #(.WIDTH(WIDTH), .PRE_WIDTH(PRE_WIDTH)) bus ();

  timer_core #(.WIDTH(WIDTH), .PRE_WIDTH(PRE_WIDTH)) dut (
    .clk   (clk),
    .clr_b (clr_b),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish required finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic row(input logic en, input logic mode, input logic load,
                     input logic [WIDTH-1:0] lv, input logic [PRE_WIDTH-1:0] ps,
                     input logic clr, input logic [WIDTH-1:0] ec, input logic et,
                     input logic ei, input logic er);
    vec_t v;
    v.en = en; v.mode = mode; v.load = load; v.load_val = lv; v.prescale = ps;
    v.irq_clr = clr; v.exp_count = ec; v.exp_tick = et; v.exp_irq = ei;
    v.exp_running = er;
    table_q.push_back(v);
  endtask

  task automatic drive(input vec_t v);
    bus.en       = v.en;
    bus.mode     = v.mode;
    bus.load     = v.load;
    bus.load_val = v.load_val;
    bus.prescale = v.prescale;
    bus.irq_clr  = v.irq_clr;
  endtask

  task automatic apply(input vec_t v, input int idx);
    vec_t e;
    @(negedge clk);
    drive(v);
    sb_q.push_back(v);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard[%0d]: got empty queue required one entry", idx);
    end else begin
      e = sb_q.pop_front();
      $display("vec %0d: load=%0b lv=%0d ps=%0d en=%0b clr=%0b -> count=%0d tick=%0b irq=%0b run=%0b",
               idx, v.load, v.load_val, v.prescale, v.en, v.irq_clr,
               bus.count, bus.tick, bus.irq, bus.running);
      check("count",   idx, 32'(bus.count),   32'(e.exp_count));
      check("tick",    idx, 32'(bus.tick),    32'(e.exp_tick));
      check("irq",     idx, 32'(bus.irq),     32'(e.exp_irq));
      check("running", idx, 32'(bus.running), 32'(e.exp_running));
    end
  endtask

  initial begin
    vec_t v;
    checks = 0;
    errors = 0;

    // Reset held with random inputs: outputs must stay at reset values.
    clr_b = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.en       = 1'($urandom);
      bus.mode     = 1'($urandom);
      bus.load     = 1'($urandom);
      bus.load_val = WIDTH'($urandom);
      bus.prescale = PRE_WIDTH'($urandom);
      bus.irq_clr  = 1'($urandom);
      @(posedge clk);
      #1;
      $display("reset %0d: count=%0d tick=%0b irq=%0b run=%0b",
               i, bus.count, bus.tick, bus.irq, bus.running);
      check("rst_count",   i, 32'(bus.count),   0);
      check("rst_tick",    i, 32'(bus.tick),    0);
      check("rst_irq",     i, 32'(bus.irq),     0);
      check("rst_running", i, 32'(bus.running), 0);
    end
    @(negedge clk);
    bus.en = 1'b1; bus.mode = 1'b0; bus.load = 1'b0; bus.load_val = '0;
    bus.prescale = '0; bus.irq_clr = 1'b0;
    clr_b = 1'b1;

    // Idle after release: no load, nothing moves.
    row(1,0,0,0,2,0, 0,0,0,0);
    row(1,0,0,0,2,0, 0,0,0,0);
    // One-shot: prescale 2, load 3 -> decrements every 3 clocks, expiry 9 clocks after load.
    row(1,0,1,3,2,0, 3,0,0,1);
    row(1,0,0,0,2,0, 3,0,0,1);
    row(1,0,0,0,2,0, 3,0,0,1);
    row(1,0,0,0,2,0, 2,1,0,1);
    row(1,0,0,0,2,0, 2,0,0,1);
    row(1,0,0,0,2,0, 2,0,0,1);
    row(1,0,0,0,2,0, 1,1,0,1);
    row(1,0,0,0,2,0, 1,0,0,1);
    row(1,0,0,0,2,0, 1,0,0,1);
    row(1,0,0,0,2,0, 0,1,1,0);
    row(1,0,0,0,2,0, 0,0,1,0);
    row(1,0,0,0,2,1, 0,0,0,0);
    row(1,0,0,0,2,0, 0,0,0,0);
    // Periodic: prescale 0, load 4 -> tick every clock, reload with no dead cycle.
    row(1,1,1,4,0,0, 4,0,0,1);
    for (int k = 0; k < 12; k++) begin
      row(1,1,0,0,0,0, WIDTH'((k % 4 == 3) ? 4 : 3 - (k % 4)), 1, (k >= 3), 1);
    end
    // Load collides with a decrement: load wins, pre_cnt restarts from 0.
    row(1,1,1,7,0,0, 7,0,1,1);
    row(1,1,0,0,1,0, 7,0,1,1);
    row(1,1,0,0,1,0, 6,1,1,1);
    row(1,1,0,0,1,1, 6,0,0,1);
    // Zero load: straight to IDLE, no irq.
    row(1,0,1,0,1,0, 0,0,0,0);
    row(1,0,0,0,1,0, 0,0,0,0);
    // irq_clr on the expiry cycle: set wins, one-shot still lands in DONE.
    row(1,0,1,1,0,0, 1,0,0,1);
    row(1,0,0,0,0,1, 0,1,1,0);
    row(1,0,0,0,0,0, 0,0,1,0);
    row(1,0,0,0,0,1, 0,0,0,0);
    // Pause 5 clocks mid-period: expiry moves from load+4 to load+9.
    row(1,0,1,2,1,0, 2,0,0,1);
    row(1,0,0,0,1,0, 2,0,0,1);
    for (int k = 0; k < 5; k++) row(0,0,0,0,1,0, 2,0,0,1);
    row(1,0,0,0,1,0, 1,1,0,1);
    row(1,0,0,0,1,0, 1,0,0,1);
    row(1,0,0,0,1,0, 0,1,1,0);
    row(1,0,0,0,1,1, 0,0,0,0);

    for (int i = 0; i < table_q.size(); i++) begin
      apply(table_q[i], i);
    end

    // Async reset mid-run with count = 5: reset values appear before the next edge.
    row(1,0,1,8,0,0, 8,0,0,1);
    row(1,0,0,0,0,0, 7,1,0,1);
    row(1,0,0,0,0,0, 6,1,0,1);
    row(1,0,0,0,0,0, 5,1,0,1);
    for (int i = table_q.size() - 4; i < table_q.size(); i++) begin
      apply(table_q[i], i);
    end
    #2;
    clr_b = 1'b0;
    #1;
    $display("async reset: count=%0d tick=%0b irq=%0b run=%0b",
             bus.count, bus.tick, bus.irq, bus.running);
    check("async_count",   0, 32'(bus.count),   0);
    check("async_tick",    0, 32'(bus.tick),    0);
    check("async_irq",     0, 32'(bus.irq),     0);
    check("async_running", 0, 32'(bus.running), 0);
    @(negedge clk);
    clr_b = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      $display("post reset %0d: count=%0d tick=%0b run=%0b",
               i, bus.count, bus.tick, bus.running);
      check("post_count",   i, 32'(bus.count),   0);
      check("post_tick",    i, 32'(bus.tick),    0);
      check("post_running", i, 32'(bus.running), 0);
    end

    // A fresh load after reset restarts normally.
    v = '{en:1, mode:0, load:1, load_val:5, prescale:0, irq_clr:0,
          exp_count:5, exp_tick:0, exp_irq:0, exp_running:1};
    apply(v, 1000);
    v = '{en:1, mode:0, load:0, load_val:0, prescale:0, irq_clr:0,
          exp_count:4, exp_tick:1, exp_irq:0, exp_running:1};
    apply(v, 1001);

    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries left required 0", sb_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
